// File: rtl/hex_blink_ctrl.sv
// Avalon-MM controlled 7-segment driver with enable, blink and polarity control.
// Also tracks a sticky change flag on the upstream segment pattern.
module hex_blink_ctrl #(
  parameter logic [25:0] DEFAULT_PERIOD = 26'd24999999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [6:0]  seg_in,
  output logic [6:0]  hex_out
);

  logic [2:0]  ctrl_q,   ctrl_d;
  logic [25:0] period_q, period_d;
  logic [25:0] cnt_q,    cnt_d;
  logic        phase_q,  phase_d;
  logic [6:0]  seg_q;
  logic        chg_q,    chg_d;
  logic [6:0]  hex_q,    hex_d;

  logic wr, restart, lit;
  logic unused_wd;

  assign unused_wd = ^writedata[31:26];
  assign wr        = chipselect & ~write_n;
  // A new period or switching blink on restarts the half-period lit.
  assign restart   = wr & ((address == 2'd1) |
                           ((address == 2'd0) & writedata[1] & ~ctrl_q[1]));
  assign lit       = ctrl_q[0] & (~ctrl_q[1] | phase_q);

  always_comb begin
    ctrl_d   = ctrl_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (wr && address == 2'd0) ctrl_d   = writedata[2:0];
    if (wr && address == 2'd1) period_d = writedata[25:0];
    if (restart || !ctrl_q[1]) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 26'd1;
    end
    if (lit) hex_d = ctrl_q[2] ? seg_in : ~seg_in;
    else     hex_d = ctrl_q[2] ? 7'h00  : 7'h7F;
    // Set beats a simultaneous clear so no change event is lost.
    chg_d = (seg_in != seg_q) | (chg_q & ~(wr & (address == 2'd2) & writedata[1]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= 3'b001;
      period_q <= DEFAULT_PERIOD;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      seg_q    <= '0;
      chg_q    <= 1'b0;
      hex_q    <= 7'h7F;
    end else begin
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      seg_q    <= seg_in;
      chg_q    <= chg_d;
      hex_q    <= hex_d;
    end
  end

  always_comb begin
    case (address)
      2'd0:    readdata = {29'b0, ctrl_q};
      2'd1:    readdata = {6'b0, period_q};
      2'd2:    readdata = {30'b0, chg_q, phase_q};
      default: readdata = 32'b0;
    endcase
  end

  assign hex_out = hex_q;

endmodule

// File: tb/tb_hex_blink_ctrl.sv
// Directed bench for hex_blink_ctrl: register access, blink timing, polarity, CHG flag.
module tb_hex_blink_ctrl;

  localparam logic [25:0] DEF = 26'd24999999;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [6:0]  seg_in = '0;
  logic [6:0]  hex_out;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] d;

  hex_blink_ctrl #(.DEFAULT_PERIOD(DEF)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .seg_in(seg_in), .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1 v = readdata;
  endtask

  initial begin
    // Reset behaviour and first cycle after release
    seg_in = 7'h3F;
    repeat (2) @(negedge clk);
    chk("hex_in_reset", {25'b0, hex_out}, 32'h7F);
    rd(2'd0, d); chk("ctrl_rst", d, 32'h1);
    rd(2'd1, d); chk("period_rst", d, {6'b0, DEF});
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("hex_after_rel", {25'b0, hex_out}, 32'h40);
    rd(2'd2, d); chk("status_chg", d, 32'h3);

    // Blink PERIOD=3: 4 lit / 4 dark
    @(negedge clk) seg_in = 7'h06;
    wr(2'd0, 32'h3);
    wr(2'd1, 32'h3);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("blink3_%0d", i), {25'b0, hex_out}, (i % 8 < 4) ? 32'h79 : 32'h7F);
    end
    rd(2'd0, d); chk("ctrl_rd", d, 32'h3);
    rd(2'd1, d); chk("period_rd", d, 32'h3);

    // PERIOD=0 toggles every cycle
    @(negedge clk);
    wr(2'd1, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("p0_hex_%0d", i), {25'b0, hex_out}, (i % 2 == 0) ? 32'h79 : 32'h7F);
      rd(2'd2, d);
      chk($sformatf("p0_phase_%0d", i), {31'b0, d[0]}, (i % 2 == 0) ? 32'h0 : 32'h1);
    end

    // Active-high polarity, then disable
    @(negedge clk) seg_in = 7'h5B;
    wr(2'd0, 32'h5);
    @(negedge clk);
    chk("ah_lit", {25'b0, hex_out}, 32'h5B);
    wr(2'd0, 32'h4);
    chk("ah_latency", {25'b0, hex_out}, 32'h5B);
    @(negedge clk);
    chk("ah_off", {25'b0, hex_out}, 32'h00);

    // PERIOD rewrite mid-count restarts the half-period
    seg_in = 7'h06;
    wr(2'd0, 32'h3);
    wr(2'd1, 32'd20);
    repeat (7) @(negedge clk);
    wr(2'd1, 32'd10);
    rd(2'd2, d); chk("restart_phase", {31'b0, d[0]}, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rd(2'd2, d); chk($sformatf("p10_hold_%0d", k), {31'b0, d[0]}, 32'h1);
    end
    @(negedge clk);
    rd(2'd2, d); chk("p10_toggle", {31'b0, d[0]}, 32'h0);
    rd(2'd1, d); chk("p10_rd", d, 32'd10);

    // Asynchronous reset mid-blink
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_rst_hex", {25'b0, hex_out}, 32'h7F);
    rd(2'd0, d); chk("async_rst_ctrl", d, 32'h1);
    rd(2'd2, d); chk("async_rst_status", d, 32'h1);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("rst_resume_hex", {25'b0, hex_out}, 32'h79);

    // CHG: set wins over clear, then clear with stable input
    @(negedge clk);
    seg_in = 7'h4F;
    wr(2'd2, 32'h2);
    rd(2'd2, d); chk("chg_set_wins", {31'b0, d[1]}, 32'h1);
    wr(2'd2, 32'h2);
    rd(2'd2, d); chk("chg_cleared", {31'b0, d[1]}, 32'h0);

    // Reserved address, unselected write, masked upper bits
    @(negedge clk);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d); chk("rsvd_rd", d, 32'h0);
    address = 2'd1; writedata = 32'h7; chipselect = 1'b0; write_n = 1'b0;
    @(negedge clk) write_n = 1'b1;
    rd(2'd1, d); chk("cs_low_ignored", d, {6'b0, DEF});
    @(negedge clk);
    wr(2'd1, 32'hFC00_0005);
    rd(2'd1, d); chk("period_mask", d, 32'h5);
    wr(2'd0, 32'hFFFF_FFF8);
    rd(2'd0, d); chk("ctrl_mask", d, 32'h0);
    @(negedge clk);
    chk("disabled_low", {25'b0, hex_out}, 32'h7F);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hex_blink_ctrl.md
HEX_BLINK_CTRL -- requirements
Module: hex_blink_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_PERIOD, default 26'd24999999, reset value of PERIOD register (0.5 s half-period at 50 MHz).
REQ-002 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port address  input  2  Avalon-MM register select.
REQ-005 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-006 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-007 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-008 SHALL have port readdata  output  32  Avalon-MM read data.
REQ-009 SHALL have port seg_in  input  7  segment pattern from the upstream 7-bit HEX output port; bit=1 means segment lit; bit0=seg a ... bit6=seg g.
REQ-010 SHALL have port hex_out  output  7  registered segment drive to board pins, polarity per CTRL.ACTIVE_HIGH.

Function
REQ-011 SHALL decode registers: 0=CTRL, 1=PERIOD, 2=STATUS, 3=reserved.
REQ-012 SHALL implement CTRL[2:0]: bit0 EN (display enable), bit1 BLINK, bit2 ACTIVE_HIGH; bits 31:3 read 0, writes ignored.
REQ-013 SHALL implement PERIOD[25:0] as blink half-period minus one in clk cycles; bits 31:26 read 0, writes ignored.
REQ-014 SHALL implement STATUS read as {30'b0, CHG, PHASE}; write of writedata[1]=1 clears CHG, all other STATUS write bits ignored.
REQ-015 SHALL perform a write when chipselect=1 and write_n=0, taking effect at that clock edge; reads of address 3 return 0; writes to address 3 ignored.
REQ-016 SHALL drive readdata combinationally from address and current register values (zero wait states, no read side effects).
REQ-017 SHALL run a 26-bit counter CNT while BLINK=1: CNT==PERIOD -> CNT<=0 and PHASE toggles; otherwise CNT<=CNT+1; PERIOD=0 toggles PHASE every cycle.
REQ-018 SHALL hold CNT at 0 and PHASE at 1 while BLINK=0.
REQ-019 SHALL, on a write to PERIOD, or a CTRL write changing BLINK 0->1, force CNT<=0 and PHASE<=1 in that cycle (restart overrides counting).
REQ-020 SHALL, if PERIOD is written below current CNT, never let CNT wrap past 2^26-1; REQ-019 restart guarantees this.
REQ-021 SHALL compute LIT = EN & (~BLINK | PHASE).
REQ-022 SHALL register hex_out each cycle: LIT=1 -> (ACTIVE_HIGH ? seg_in : ~seg_in); LIT=0 -> (ACTIVE_HIGH ? 7'h00 : 7'h7F).
REQ-023 SHALL give hex_out a latency of exactly one clk from any change of seg_in, CTRL or PHASE.
REQ-024 SHALL register seg_in into SEG_Q each cycle and set sticky CHG when seg_in != SEG_Q.
REQ-025 SHALL let set win over clear when a CHG-set condition and a STATUS clear write occur in the same cycle.

Reset
REQ-026 SHALL, on reset_n=0, asynchronously set CTRL=3'b001, PERIOD=DEFAULT_PERIOD, CNT=0, PHASE=1, SEG_Q=0, CHG=0, hex_out=7'h7F.
REQ-027 SHALL resume normal operation on the first rising clk edge after reset_n deasserts; reset mid-blink abandons the count without glitching hex_out beyond the reset value.

Verification
REQ-028 SHALL cover: reset, seg_in=7'h3F -> hex_out=7'h7F during reset, hex_out=7'h40 one clk after release; CHG=1 read at address 2.
REQ-029 SHALL cover: write CTRL=3'b011, PERIOD=3, seg_in=7'h06 -> hex_out alternates 7'h79 (4 clks) / 7'h7F (4 clks), starting lit.
REQ-030 SHALL cover: PERIOD=0 with BLINK=1 -> PHASE and hex_out toggle every clk.
REQ-031 SHALL cover: CTRL=3'b101, seg_in=7'h5B -> hex_out=7'h5B; CTRL=3'b100 -> hex_out=7'h00 next clk.
REQ-032 SHALL cover: write PERIOD=10 mid-count (CNT=7 of PERIOD=20) -> CNT=0, PHASE=1 next clk; next toggle after 11 clks.
REQ-033 SHALL cover: STATUS write 32'h2 in the same cycle seg_in changes -> CHG remains 1; a later clear with stable seg_in -> CHG=0.
